// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) layout, sizes and encode helpers used by both the
// transmit serializer and the far-end single-error corrector.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;

  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D3 = 2;
  localparam int P4 = 3;
  localparam int D5 = 4;
  localparam int D6 = 5;
  localparam int D7 = 6;

  localparam logic [2:0] INJ_NONE = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] h;
    h     = '0;
    h[D3] = d[0];
    h[D5] = d[1];
    h[D6] = d[2];
    h[D7] = d[3];
    h[P1] = h[D3] ^ h[D5] ^ h[D7];
    h[P2] = h[D3] ^ h[D6] ^ h[D7];
    h[P4] = h[D5] ^ h[D6] ^ h[D7];
    return h;
  endfunction

  // Single-bit flip mask; position 7 means "leave the word alone".
  function automatic logic [CODE_W-1:0] inject_mask(input logic en, input logic [2:0] pos);
    logic [CODE_W-1:0] m;
    m = '0;
    if (en && (pos != INJ_NONE)) m[pos] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hamming_tx_serializer_encoder.sv
// Purely combinational nibble-to-codeword Hamming(7,4) encoder.
module hamming_encoder_core
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  assign code = hamming_encode(data);

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming(7,4) transmit path: handshake in, optional single-bit error
// injection, one-deep holding register, gapless serial frame out.
module hamming_tx_serializer
  import hamming_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              inj_en,
  input  logic [2:0]        inj_pos,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_last,
  output logic [CODE_W-1:0] code_out,
  output logic              busy
);

  localparam int FIRST = (LSB_FIRST != 0) ? 0 : CODE_W - 1;

  logic [CODE_W-1:0] enc_code;
  logic [CODE_W-1:0] inj_code;
  logic [CODE_W-1:0] hold_p0;
  logic [CODE_W-1:0] shift_p1;
  logic              hold_full;
  ser_state_t        state;
  logic [2:0]        cnt;
  logic              accept;
  logic              frame_end;
  logic              load;

  function automatic logic [CODE_W-1:0] shift_next(input logic [CODE_W-1:0] s);
    return (LSB_FIRST != 0) ? (s >> 1) : (s << 1);
  endfunction

  hamming_encoder_core u_enc (
    .data (data_in),
    .code (enc_code)
  );

  assign inj_code   = enc_code ^ inject_mask(inj_en, inj_pos);
  assign data_ready = !hold_full && !rst;
  assign accept     = data_valid && data_ready;
  assign frame_end  = (state == ST_SHIFT) && (cnt == 3'd6);
  // Reload on the last bit edge too, so consecutive frames have no bubble.
  assign load       = hold_full && ((state == ST_IDLE) || frame_end);
  assign busy       = (state == ST_SHIFT) || hold_full;

  // Stage p0: holding register, written at acceptance
  always_ff @(posedge clk) begin
    if (accept) hold_p0 <= inj_code;
  end

  // Stage p1: shift register holds the bits not yet presented on tx_bit
  always_ff @(posedge clk) begin
    if (load) shift_p1 <= shift_next(hold_p0);
    else if (state == ST_SHIFT) shift_p1 <= shift_next(shift_p1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      hold_full <= 1'b0;
      tx_bit    <= 1'b0;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
      code_out  <= '0;
    end else begin
      // accept needs an empty hold, load needs a full one: never both
      if (accept) hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;

      if (load) begin
        state    <= ST_SHIFT;
        cnt      <= 3'd0;
        code_out <= hold_p0;
        tx_bit   <= hold_p0[FIRST];
        tx_valid <= 1'b1;
        tx_last  <= 1'b0;
      end else if (state == ST_SHIFT) begin
        if (frame_end) begin
          state    <= ST_IDLE;
          cnt      <= 3'd0;
          tx_bit   <= 1'b0;
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
        end else begin
          cnt     <= cnt + 3'd1;
          tx_bit  <= shift_p1[FIRST];
          tx_last <= (cnt == 3'd5);
        end
      end
    end
  end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Directed self-checking bench: LSB-first and MSB-first instances share inputs.
module tb_hamming_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       data_valid;
  logic       inj_en;
  logic [2:0] inj_pos;

  logic       l_ready, l_bit, l_valid, l_last, l_busy;
  logic [6:0] l_code;
  logic       m_ready, m_bit, m_valid, m_last, m_busy;
  logic [6:0] m_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_tx_serializer #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(l_ready), .inj_en(inj_en), .inj_pos(inj_pos),
    .tx_bit(l_bit), .tx_valid(l_valid), .tx_last(l_last),
    .code_out(l_code), .busy(l_busy)
  );

  hamming_tx_serializer #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(m_ready), .inj_en(inj_en), .inj_pos(inj_pos),
    .tx_bit(m_bit), .tx_valid(m_valid), .tx_last(m_last),
    .code_out(m_code), .busy(m_busy)
  );

  // Far-end single-error corrector: syndrome gives the 1-based flipped position.
  function automatic logic [6:0] correct(input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] r;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    r = c;
    if (s != 3'd0) r[s - 3'd1] = ~r[s - 3'd1];
    return r;
  endfunction

  // Caller is positioned 1 time unit after a rising edge with the serializer idle.
  task automatic send_frame(input logic [3:0] d, input logic en, input logic [2:0] pos,
                            input logic [6:0] exp_code, input string name);
    data_in = d; inj_en = en; inj_pos = pos; data_valid = 1'b1;
    checks++;
    if (l_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before_accept got %b want 1", name, l_ready);
    end
    @(posedge clk); #1;
    data_valid = 1'b0; inj_en = 1'b0; inj_pos = 3'd7;
    checks++;
    if (l_valid !== 1'b0 || l_busy !== 1'b1) begin
      errors++; $display("FAIL %s held_not_sent valid=%b busy=%b want 0/1", name, l_valid, l_busy);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (l_valid !== 1'b1 || l_bit !== exp_code[i] || l_last !== (i == 6)) begin
        errors++;
        $display("FAIL %s lsb_bit%0d got v=%b b=%b l=%b want 1/%b/%b",
                 name, i, l_valid, l_bit, l_last, exp_code[i], (i == 6));
      end
      checks++;
      if (m_valid !== 1'b1 || m_bit !== exp_code[6-i] || m_last !== (i == 6)) begin
        errors++;
        $display("FAIL %s msb_bit%0d got v=%b b=%b l=%b want 1/%b/%b",
                 name, i, m_valid, m_bit, m_last, exp_code[6-i], (i == 6));
      end
      checks++;
      if (l_code !== exp_code || m_code !== exp_code) begin
        errors++; $display("FAIL %s code_out got %b/%b want %b", name, l_code, m_code, exp_code);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (l_valid !== 1'b0 || l_busy !== 1'b0 || l_last !== 1'b0 || l_bit !== 1'b0) begin
      errors++;
      $display("FAIL %s after_frame got v=%b busy=%b l=%b b=%b want 0", name, l_valid, l_busy, l_last, l_bit);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; data_in = 4'd0; data_valid = 1'b0; inj_en = 1'b0; inj_pos = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({l_bit, l_valid, l_last, l_busy, l_ready} !== 5'b0 || l_code !== 7'b0) begin
      errors++;
      $display("FAIL reset_lsb got bit/valid/last/busy/ready=%b code=%b want 0",
               {l_bit, l_valid, l_last, l_busy, l_ready}, l_code);
    end
    checks++;
    if ({m_bit, m_valid, m_last, m_busy, m_ready} !== 5'b0 || m_code !== 7'b0) begin
      errors++;
      $display("FAIL reset_msb got bit/valid/last/busy/ready=%b code=%b want 0",
               {m_bit, m_valid, m_last, m_busy, m_ready}, m_code);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (l_ready !== 1'b1 || m_ready !== 1'b1 || l_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release ready=%b/%b valid=%b want 1/1/0", l_ready, m_ready, l_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_encode;
    send_frame(4'b0000, 1'b0, 3'd7, 7'b0000000, "enc_0000");
    send_frame(4'b1111, 1'b0, 3'd7, 7'b1111111, "enc_1111");
    send_frame(4'b0001, 1'b0, 3'd7, 7'b0000111, "enc_0001");
    send_frame(4'b1011, 1'b0, 3'd7, 7'b1010101, "enc_1011");
  endtask

  task automatic test_inject;
    send_frame(4'b1011, 1'b1, 3'd3, 7'b1011101, "inj_pos3");
    checks++;
    if (correct(l_code) !== 7'b1010101) begin
      errors++; $display("FAIL inj_corrected got %b want 1010101", correct(l_code));
    end
    send_frame(4'b1011, 1'b1, 3'd7, 7'b1010101, "inj_pos7");
    send_frame(4'b1011, 1'b0, 3'd3, 7'b1010101, "inj_disabled");
    send_frame(4'b0000, 1'b1, 3'd6, 7'b1000000, "inj_pos6");
  endtask

  task automatic test_back_to_back;
    logic [3:0] nib [3];
    logic [6:0] codes [3];
    int idx, vc;
    logic rdy_now, started, exp_bit;
    nib[0] = 4'b0001; codes[0] = 7'b0000111;
    nib[1] = 4'b1011; codes[1] = 7'b1010101;
    nib[2] = 4'b1111; codes[2] = 7'b1111111;
    idx = 0; vc = 0; started = 1'b0;
    data_in = nib[0]; data_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      rdy_now = l_ready;
      @(posedge clk); #1;
      if (rdy_now && data_valid) begin
        idx++;
        checks++;
        if (l_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_ready_low_when_full cyc%0d got %b want 0", cyc, l_ready);
        end
        if (idx == 3) data_valid = 1'b0;
        else data_in = nib[idx];
      end
      if (l_valid === 1'b1) started = 1'b1;
      if (started && vc < 21) begin
        exp_bit = codes[vc / 7][vc % 7];
        checks++;
        if (l_valid !== 1'b1 || l_bit !== exp_bit || l_last !== ((vc % 7) == 6) || l_busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_bit%0d got v=%b b=%b l=%b busy=%b want 1/%b/%b/1",
                   vc, l_valid, l_bit, l_last, l_busy, exp_bit, ((vc % 7) == 6));
        end
        vc++;
      end
    end
    data_valid = 1'b0;
    checks++;
    if (vc !== 21 || l_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_total got %0d bits valid=%b want 21/0", vc, l_valid);
    end
  endtask

  task automatic test_reset_midframe;
    data_in = 4'b1111; inj_en = 1'b0; inj_pos = 3'd7; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (l_valid !== 1'b1 || l_bit !== 1'b1 || l_last !== 1'b0) begin
      errors++; $display("FAIL mid_before got v=%b b=%b l=%b want 1/1/0", l_valid, l_bit, l_last);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({l_bit, l_valid, l_last, l_busy, l_ready} !== 5'b0 || l_code !== 7'b0) begin
      errors++;
      $display("FAIL mid_async_reset got bit/valid/last/busy/ready=%b code=%b want 0",
               {l_bit, l_valid, l_last, l_busy, l_ready}, l_code);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if (l_ready !== 1'b1 || l_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release ready=%b valid=%b want 1/0", l_ready, l_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (l_valid !== 1'b0 || l_busy !== 1'b0) begin
      errors++; $display("FAIL mid_not_resumed valid=%b busy=%b want 0/0", l_valid, l_busy);
    end
    send_frame(4'b0001, 1'b0, 3'd7, 7'b0000111, "after_reset");
  endtask

  initial begin
    test_reset;
    test_encode;
    test_inject;
    test_back_to_back;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_tx_serializer.md
# hamming_tx_serializer

Transmit-side partner of the Hamming(7,4) error-correction path. Accepts 4-bit data words over a valid/ready handshake and encodes each into a 7-bit Hamming codeword. Optionally flips one codeword bit for test, then shifts the codeword out serially, one bit per clock, with frame markers. Its serial output feeds the channel whose far end reassembles 7-bit words and runs them through the single-error corrector.

## Interface
Parameters:
- `LSB_FIRST`, default 1: 1 = transmit h[0] first; 0 = transmit h[6] first.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `data_in` input 4: data nibble d[3:0].
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: block can accept a nibble this cycle.
- `inj_en` input 1: enable error injection, sampled at acceptance.
- `inj_pos` input 3: codeword bit to flip, 0..6; 7 = no flip.
- `tx_bit` output 1: serial codeword bit.
- `tx_valid` output 1: `tx_bit` is a valid codeword bit.
- `tx_last` output 1: final (7th) bit of the current codeword.
- `code_out` output 7: parallel copy of the codeword being shifted, stable for the whole frame.
- `busy` output 1: serializer in SHIFT or holding register full.

## Operation
- Codeword layout, h6..h0 = D7 D6 D5 P4 D3 P2 P1:
  - Data bits: h2=d0, h4=d1, h5=d2, h6=d3.
  - Parity bits: h0 = h2^h4^h6; h1 = h2^h5^h6; h3 = h4^h5^h6 (even parity).
- Acceptance: occurs on a rising edge where `data_valid && data_ready`.
  - The encoded word is written into a 7-bit holding register and `hold_full` is set.
  - If `inj_en=1` and `inj_pos`<=6, bit `inj_pos` is inverted before storage.
  - `inj_pos=7` stores the word unmodified.
- `data_ready = !hold_full && !rst`.
- Serializer FSM, states IDLE and SHIFT, 3-bit bit counter `cnt`:
  - IDLE: if `hold_full`, load the shift register and `code_out` from hold, clear `hold_full`, set `cnt=0`, go to SHIFT.
  - SHIFT: one bit per cycle; `cnt` increments 0..6.
  - SHIFT at `cnt=6` with `hold_full`: reload from hold on the same edge, `cnt=0`, stay in SHIFT. There is no idle bubble between frames.
  - SHIFT at `cnt=6` without `hold_full`: go to IDLE.
- Bit order: `LSB_FIRST=1` sends h0..h6; `LSB_FIRST=0` sends h6..h0.
- Outputs during SHIFT:
  - `tx_valid=1`.
  - `tx_last=1` exactly when `cnt=6`.
  - `tx_bit` = the current bit.
- Outputs in IDLE: `tx_valid=0`, `tx_last=0`, `tx_bit=0`.
- Simultaneous load and accept: the hold register is emptied by a load on the same edge that it would be written only if `data_ready` was already 1. This cannot occur, because ready requires empty hold. Acceptance and loading therefore never collide.
- Reset at any time, including mid-frame:
  - IDLE; `hold_full=0`; `cnt=0`.
  - `tx_bit`, `tx_valid`, `tx_last`, `busy` = 0; `code_out=7'b0`; `data_ready=0` while `rst` is high.
  - A partially sent frame is abandoned, never resumed.

## Timing
- All outputs are registered except `data_ready` and `busy`, which are decoded from registered state.
- Latency: a nibble accepted at edge k is loaded at edge k+1 (serializer in IDLE). The first bit with `tx_valid=1` is visible in the cycle after edge k+1.
- Frame length: exactly 7 consecutive `tx_valid` cycles.
- Sustained throughput: one codeword per 7 cycles. `data_ready` returns 1 the cycle after each load, so a source can keep hold full with no gaps.
- After `rst` deasserts: `data_ready=1` in the first cycle.

## Structure
- Package `hamming_pkg`:
  - Constants: `DATA_W=4`, `CODE_W=7`.
  - Bit-position constants: P1=0, P2=1, D3=2, P4=3, D5=4, D6=5, D7=6.
  - Function `hamming_encode(input [3:0]) -> [6:0]`.
  - The same package is imported by the corrector side so both ends share one layout.
- Sub-module `hamming_encoder_core`: purely combinational nibble-to-codeword encoder, instantiated once before the injection mux.

## Test plan
- Encode vectors, with `inj_pos=7` and LSB_FIRST:
  - d=4'b0000 -> `code_out=7'b0000000`.
  - d=4'b1111 -> 7'b1111111.
  - d=4'b0001 -> 7'b0000111.
  - d=4'b1011 -> 7'b1010101; serial stream 1,0,1,0,1,0,1 with `tx_last` on the 7th bit.
- Back-to-back: `data_valid` held high with 3 nibbles -> 21 consecutive `tx_valid` cycles, no gap, `tx_last` at cycles 7/14/21, `data_ready` low whenever hold is full.
- Injection: d=4'b1011, `inj_en=1`, `inj_pos=3` -> `code_out=7'b1011101`. Feeding the result to the corrector returns 7'b1010101.
- Injection with `inj_pos=7` and `inj_en=1` -> codeword unmodified.
- `LSB_FIRST=0`: d=4'b0001 -> serial 0,0,0,0,1,1,1.
- Reset mid-frame: assert `rst` at bit 3 of a frame -> outputs 0 immediately (asynchronous). After release, `data_ready=1`, `tx_valid=0`, and the next accepted nibble sends a full 7-bit frame.
